ddr_burst_serializer: RTL and testbench

- Upstream stage of the ODDRE1/IOBUF output path: accepts parallel words on a valid/ready stream and emits them as per-clock D1/D2 bit pairs for the ODDRE1, plus the active-low output enable for the IOBUF T pin.
- Frames each burst as preamble, data, postamble, then returns the pin to tristate. Replaces the free-running counter stimulus with real framed traffic.

---
 rtl/ddr_out_pkg.sv | 16 +
 rtl/ddr_pair_shifter.sv | 28 ++
 rtl/ddr_burst_serializer.sv | 171 +++++++++++++++++
 tb/tb_ddr_burst_serializer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_out_pkg.sv
// Shared state, preamble pattern and counter width
// for the DDR burst serializer.
package ddr_out_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      DATA,
      POST
   } ddr_state_e;

   localparam logic PRE_D1 = 1'b1;
   localparam logic PRE_D2 = 1'b0;
   localparam int   WCNT_W = 16;

endpackage

// File: rtl/ddr_pair_shifter.sv
// Word-wide load / shift-by-2 register that presents
// the next D1/D2 bit pair on its two LSBs.
module ddr_pair_shifter #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [1:0]        pair_o
);

   logic [WORD_W-1:0] sr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= data_i;
      end else if (shift_i) begin
         sr_q <= sr_q >> 2;
      end
   end

   assign pair_o = sr_q[1:0];

endmodule

// File: rtl/ddr_burst_serializer.sv
// Frames valid/ready words into preamble/data/postamble
// bursts of D1/D2 pairs plus output enable for ODDRE1/IOBUF.
module ddr_burst_serializer
   import ddr_out_pkg::*;
#(
   parameter int WORD_W        = 16,
   parameter int PREAMBLE_CYC  = 2,
   parameter int POSTAMBLE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic              d1,
   output logic              d2,
   output logic              oe_n,
   output logic              busy,
   output logic              underrun,
   output logic [WCNT_W-1:0] word_cnt
);

   localparam int BEATS = WORD_W / 2;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int MAXC  = (PREAMBLE_CYC > POSTAMBLE_CYC) ?
                          PREAMBLE_CYC : POSTAMBLE_CYC;
   localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] PRE_END   = CW'(PREAMBLE_CYC - 1);
   localparam logic [CW-1:0] POST_END  = CW'(POSTAMBLE_CYC - 1);

   if ((WORD_W % 2) != 0 || WORD_W < 2) begin : g_bad_width
      $fatal(1, "ddr_burst_serializer: WORD_W must be even and >= 2");
   end

   ddr_state_e        state_q, state_d;
   logic [BW-1:0]     beat_q;
   logic [CW-1:0]     cyc_q;
   logic              last_q;
   logic [WCNT_W-1:0] wcnt_q;
   logic              d1_q, d1_d;
   logic              d2_q, d2_d;
   logic              oe_n_q, oe_n_d;
   logic              und_q, und_d;
   logic [1:0]        pair;
   logic              accept;
   logic              last_beat;

   assign last_beat = (state_q == DATA) && (beat_q == LAST_BEAT);
   assign accept    = s_valid && s_ready;

   ddr_pair_shifter #(
      .WORD_W (WORD_W)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (state_q == DATA),
      .data_i  (s_data),
      .pair_o  (pair)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (PREAMBLE_CYC == 0) ? DATA : PRE;
            end
         end
         PRE: begin
            if (cyc_q == PRE_END) begin
               state_d = DATA;
            end
         end
         DATA: begin
            // a non-last word followed by a fresh word stays in DATA
            if (last_beat && !(s_valid && !last_q)) begin
               state_d = (POSTAMBLE_CYC == 0) ? IDLE : POST;
            end
         end
         POST: begin
            if (cyc_q == POST_END) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_ready = 1'b0;
      d1_d    = 1'b0;
      d2_d    = 1'b0;
      oe_n_d  = 1'b1;
      und_d   = 1'b0;
      case (state_q)
         IDLE: s_ready = enable;
         PRE: begin
            oe_n_d = 1'b0;
            d1_d   = PRE_D1;
            d2_d   = PRE_D2;
         end
         DATA: begin
            oe_n_d  = 1'b0;
            d1_d    = pair[0];
            d2_d    = pair[1];
            s_ready = last_beat && !last_q;
            und_d   = last_beat && !last_q && !s_valid;
         end
         POST: oe_n_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d1_q   <= 1'b0;
         d2_q   <= 1'b0;
         oe_n_q <= 1'b1;
         und_q  <= 1'b0;
         beat_q <= '0;
         cyc_q  <= '0;
         last_q <= 1'b0;
         wcnt_q <= '0;
      end else begin
         d1_q   <= d1_d;
         d2_q   <= d2_d;
         oe_n_q <= oe_n_d;
         und_q  <= und_d;
         if (accept) begin
            last_q <= s_last;
         end
         if (state_q == DATA && !last_beat) begin
            beat_q <= beat_q + 1'b1;
         end else begin
            beat_q <= '0;
         end
         // restart the phase counter on every state change
         if (state_d == state_q) begin
            cyc_q <= cyc_q + 1'b1;
         end else begin
            cyc_q <= '0;
         end
         if (state_q == IDLE && accept) begin
            wcnt_q <= '0;
         end else if (last_beat && wcnt_q != '1) begin
            wcnt_q <= wcnt_q + 1'b1;
         end
      end
   end

   assign d1       = d1_q;
   assign d2       = d2_q;
   assign oe_n     = oe_n_q;
   assign underrun = und_q;
   assign busy     = (state_q != IDLE);
   assign word_cnt = wcnt_q;

endmodule

// File: tb/tb_ddr_burst_serializer.sv
// Bench for ddr_burst_serializer: two builds (2/1 and 0/0 framing)
// share stimulus; a queue-of-pin-beats model checks every cycle.
module tb_ddr_burst_serializer;

   localparam int W     = 16;
   localparam int PRE0  = 2;
   localparam int POST0 = 1;
   localparam int BEATS = W / 2;
   localparam int QN    = 64;

   localparam logic [1:0] K_BEAT = 2'd0;
   localparam logic [1:0] K_MORE = 2'd1;
   localparam logic [1:0] K_END  = 2'd2;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         s_valid;
   logic         s_last;
   logic [W-1:0] s_data;

   logic         s_ready  [2];
   logic         d1       [2];
   logic         d2       [2];
   logic         oe_n     [2];
   logic         busy     [2];
   logic         underrun [2];
   logic [15:0]  word_cnt [2];

   ddr_burst_serializer #(
      .WORD_W        (W),
      .PREAMBLE_CYC  (PRE0),
      .POSTAMBLE_CYC (POST0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready[0]),
      .d1       (d1[0]),
      .d2       (d2[0]),
      .oe_n     (oe_n[0]),
      .busy     (busy[0]),
      .underrun (underrun[0]),
      .word_cnt (word_cnt[0])
   );

   ddr_burst_serializer #(
      .WORD_W        (W),
      .PREAMBLE_CYC  (0),
      .POSTAMBLE_CYC (0)
   ) dut0 (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready[1]),
      .d1       (d1[1]),
      .d2       (d2[1]),
      .oe_n     (oe_n[1]),
      .busy     (busy[1]),
      .underrun (underrun[1]),
      .word_cnt (word_cnt[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model: a queue of future pin beats, one popped per clock
   typedef struct packed {
      logic       oe_n;
      logic       d1;
      logic       d2;
      logic [1:0] kind;
   } item_t;

   item_t       mbuf  [2][QN];
   int          mhead [2];
   int          mcnt  [2];
   logic        e_oe  [2];
   logic        e_d1  [2];
   logic        e_d2  [2];
   logic        e_und [2];
   logic [15:0] e_wc  [2];

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(string nm, int inst,
                      logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h",
                     nm, inst, $time, act, exp);
      end
   endtask

   function automatic int npre(int i);
      return (i == 0) ? PRE0 : 0;
   endfunction

   function automatic int npost(int i);
      return (i == 0) ? POST0 : 0;
   endfunction

   function automatic bit model_ready(int i);
      if (mcnt[i] == 0) return enable;
      return mcnt[i] == 1 && mbuf[i][mhead[i]].kind == K_MORE;
   endfunction

   task automatic push(int i, item_t it);
      mbuf[i][(mhead[i] + mcnt[i]) % QN] = it;
      mcnt[i]++;
   endtask

   task automatic push_fill(int i, int n, logic dv);
      item_t it;
      it = '{oe_n: 1'b0, d1: dv, d2: 1'b0, kind: K_BEAT};
      for (int k = 0; k < n; k++) push(i, it);
   endtask

   task automatic push_word(int i, logic [W-1:0] w, logic last);
      item_t it;
      for (int k = 0; k < BEATS; k++) begin
         it.oe_n = 1'b0;
         it.d1   = w[2*k];
         it.d2   = w[2*k+1];
         if (k != BEATS - 1) it.kind = K_BEAT;
         else it.kind = last ? K_END : K_MORE;
         push(i, it);
      end
   endtask

   task automatic model_step(int i);
      item_t it;
      bit    acc;
      bit    idle;
      if (rst) begin
         mcnt[i]  = 0;
         mhead[i] = 0;
         e_oe[i]  = 1'b1;
         e_d1[i]  = 1'b0;
         e_d2[i]  = 1'b0;
         e_und[i] = 1'b0;
         e_wc[i]  = '0;
         return;
      end
      acc      = s_valid && model_ready(i);
      idle     = (mcnt[i] == 0);
      e_und[i] = 1'b0;
      if (idle) begin
         e_oe[i] = 1'b1;
         e_d1[i] = 1'b0;
         e_d2[i] = 1'b0;
      end else begin
         it       = mbuf[i][mhead[i]];
         mhead[i] = (mhead[i] + 1) % QN;
         mcnt[i]--;
         e_oe[i]  = it.oe_n;
         e_d1[i]  = it.d1;
         e_d2[i]  = it.d2;
         if (it.kind != K_BEAT && e_wc[i] != 16'hFFFF) e_wc[i]++;
         if (it.kind == K_END) begin
            push_fill(i, npost(i), 1'b0);
         end else if (it.kind == K_MORE && !acc) begin
            e_und[i] = 1'b1;
            push_fill(i, npost(i), 1'b0);
         end
      end
      if (acc) begin
         if (idle) begin
            e_wc[i] = '0;
            push_fill(i, npre(i), 1'b1);
         end
         push_word(i, s_data, s_last);
      end
   endtask

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            chk("d1", i, d1[i], e_d1[i]);
            chk("d2", i, d2[i], e_d2[i]);
            chk("oe_n", i, oe_n[i], e_oe[i]);
            chk("underrun", i, underrun[i], e_und[i]);
            chk("busy", i, busy[i], mcnt[i] != 0);
            chk("word_cnt", i, word_cnt[i], e_wc[i]);
            chk("s_ready", i, s_ready[i], model_ready(i));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(int n);
      s_valid = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      chk_on = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // directed scratch
   logic [10:0] d1v;
   logic [10:0] d2v;
   logic [2:0]  pin;
   logic [15:0] wb [3];
   int lowc, rdyc, undc, und_j, fall_j, first_j, last_j, k;
   bit take;

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      do_reset();
      chk("rst_oe_n", 0, oe_n[0], 1'b1);
      chk("rst_wcnt", 0, word_cnt[0], 16'd0);
      chk("rst_busy", 0, busy[0], 1'b0);

      // single word A5C3
      enable  = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'hA5C3;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      lowc = 0;
      fall_j = -1;
      d1v = '0;
      d2v = '0;
      for (int j = 1; j <= 13; j++) begin
         tick();
         if (!oe_n[0]) lowc++;
         if (j <= 11) begin
            d1v[j-1] = d1[0];
            d2v[j-1] = d2[0];
         end
         if (fall_j < 0 && !busy[0]) fall_j = j;
      end
      chk("A_low", 0, lowc, 11);
      chk("A_d1", 0, d1v, 11'b000_1110_0111);
      chk("A_d2", 0, d2v, 11'b011_0010_0100);
      chk("A_wcnt", 0, word_cnt[0], 16'd1);
      chk("A_busyfall", 0, fall_j, 11);

      // three words back to back
      wb[0] = 16'h0001;
      wb[1] = 16'hFFFF;
      wb[2] = 16'h8000;
      k = 0;
      rdyc = 0;
      lowc = 0;
      first_j = -1;
      last_j = -1;
      s_valid = 1'b1;
      s_data  = wb[0];
      s_last  = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (s_ready[0]) rdyc++;
         take = s_ready[0] && s_valid;
         if (!oe_n[0]) begin
            lowc++;
            if (first_j < 0) first_j = c;
            last_j = c;
         end
         tick();
         if (take) begin
            k++;
            if (k < 3) begin
               s_data = wb[k];
               s_last = (k == 2);
            end else begin
               s_valid = 1'b0;
               enable  = 1'b0;
            end
         end
      end
      chk("B_taken", 0, k, 3);
      chk("B_ready", 0, rdyc, 3);
      chk("B_low", 0, lowc, 27);
      chk("B_span", 0, last_j - first_j + 1, 27);
      chk("B_wcnt", 0, word_cnt[0], 16'd3);
      enable = 1'b1;

      // underrun after first of two words
      s_valid = 1'b1;
      s_data  = 16'h1234;
      s_last  = 1'b0;
      tick();
      s_valid = 1'b0;
      undc = 0;
      und_j = -1;
      lowc = 0;
      for (int j = 1; j <= 14; j++) begin
         tick();
         if (underrun[0]) begin
            undc++;
            und_j = j;
         end
         if (!oe_n[0]) lowc++;
      end
      chk("C_undc", 0, undc, 1);
      chk("C_undj", 0, und_j, 10);
      chk("C_low", 0, lowc, 11);
      chk("C_wcnt", 0, word_cnt[0], 16'd1);

      // reset on the 4th data beat
      s_valid = 1'b1;
      s_data  = 16'hBEEF;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int j = 1; j <= 5; j++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pin = {oe_n[0], d1[0], d2[0]};
      chk("D_pins", 0, pin, 3'b100);
      chk("D_busy", 0, busy[0], 1'b0);
      s_valid = 1'b1;
      s_data  = 16'h00FF;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      tick();
      pin = {oe_n[0], d1[0], d2[0]};
      chk("D_pre", 0, pin, 3'b010);
      idle_cycles(14);

      // enable low in idle, then dropped mid-burst
      enable  = 1'b0;
      s_valid = 1'b1;
      s_data  = 16'h5555;
      s_last  = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("E_ready", 0, s_ready[0], 1'b0);
         chk("E_oe", 0, oe_n[0], 1'b1);
         tick();
      end
      enable = 1'b1;
      s_data = 16'h1111;
      s_last = 1'b0;
      tick();
      enable = 1'b0;
      s_data = 16'h2222;
      s_last = 1'b1;
      lowc = 0;
      take = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!oe_n[0]) lowc++;
         if (s_ready[0] && s_valid) take = 1'b1;
         tick();
         if (take) s_valid = 1'b0;
      end
      chk("E_taken", 0, take, 1'b1);
      chk("E_low", 0, lowc, 19);
      chk("E_wcnt", 0, word_cnt[0], 16'd2);
      enable = 1'b1;

      // zero preamble/postamble build
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'h0003;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      lowc = 0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         pin = {oe_n[1], d1[1], d2[1]};
         if (!oe_n[1]) lowc++;
         if (j == 1) chk("F_first", 1, pin, 3'b011);
         if (j == 8) chk("F_eighth", 1, pin, 3'b000);
         if (j == 9) chk("F_release", 1, pin, 3'b100);
      end
      chk("F_low", 1, lowc, 8);
      chk("F_wcnt", 1, word_cnt[1], 16'd1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst     = ($urandom_range(0, 199) == 0);
         enable  = ($urandom_range(0, 9) != 0);
         s_valid = ($urandom_range(0, 9) < 7);
         s_last  = ($urandom_range(0, 3) == 0);
         s_data  = W'($urandom);
         tick();
      end
      rst = 1'b0;
      idle_cycles(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
